// File: rtl/lsu_controller_if.sv
// Data-memory port between the load/store controller and memory.
// Request/grant followed by a separate response/ack phase.
interface lsu_controller_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_be,
        output mem_wdata,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_be,
        input  mem_wdata,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_controller.sv
// RV32I load/store sequencer: stalls EX, drives the memory handshake,
// extends load data for writeback and raises alignment/timeout faults.
module lsu_controller #(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [9:0]       op_code,
    input  logic [31:0]      op_addr,
    input  logic [31:0]      op_wdata,
    input  logic [4:0]       op_rd,
    output logic             stall,
    lsu_controller_if.master mem,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [31:0]      wb_data,
    output logic             exc_valid,
    output logic [1:0]       exc_cause,
    output logic [31:0]      exc_addr
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        DONE,
        EXC
    } state_t;

    state_t state;
    state_t state_n;

    logic [CW-1:0] cnt;
    logic          timeout;

    logic [2:0]  f3;
    logic [6:0]  opc;
    logic        is_ld;
    logic        is_st;
    logic        accept;
    logic        sz_b;
    logic        sz_h;
    logic        sz_w;
    logic        mis;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;

    logic [31:0] addr_q;
    logic        st_q;
    logic        uns_q;
    logic [1:0]  sz_q;
    logic [4:0]  rd_q;

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_data;

    assign f3  = op_code[9:7];
    assign opc = op_code[6:0];

    always_comb begin
        is_ld = 1'b0;
        is_st = 1'b0;
        if (opc == 7'b0000011) begin
            is_ld = (f3 == 3'b000) || (f3 == 3'b001)
                 || (f3 == 3'b010) || (f3 == 3'b100)
                 || (f3 == 3'b101);
        end
        if (opc == 7'b0100011) begin
            is_st = (f3 == 3'b000) || (f3 == 3'b001)
                 || (f3 == 3'b010);
        end
    end

    assign accept = op_valid && (is_ld || is_st);
    assign sz_b   = (f3[1:0] == 2'b00);
    assign sz_h   = (f3[1:0] == 2'b01);
    assign sz_w   = (f3[1:0] == 2'b10);
    assign mis    = (sz_h && op_addr[0])
                 || (sz_w && (op_addr[1:0] != 2'b00));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = op_wdata;
        unique case (1'b1)
            sz_b: begin
                be_d    = 4'b0001 << op_addr[1:0];
                wdata_d = {4{op_wdata[7:0]}};
            end
            sz_h: begin
                be_d    = op_addr[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{op_wdata[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = op_wdata;
            end
        endcase
    end

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_v = mem.mem_rdata[7:0];
            2'd1:    byte_v = mem.mem_rdata[15:8];
            2'd2:    byte_v = mem.mem_rdata[23:16];
            default: byte_v = mem.mem_rdata[31:24];
        endcase
        half_v = addr_q[1] ? mem.mem_rdata[31:16]
                           : mem.mem_rdata[15:0];
        case (sz_q)
            2'b00: ld_data = uns_q ? {24'b0, byte_v}
                                   : {{24{byte_v[7]}}, byte_v};
            2'b01: ld_data = uns_q ? {16'b0, half_v}
                                   : {{16{half_v[15]}}, half_v};
            default: ld_data = mem.mem_rdata;
        endcase
    end

    assign timeout = (cnt >= TO_LAST);

    assign stall = ((state == IDLE) && accept)
                || (state == REQ)
                || (state == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // A grant or response in the last budgeted cycle beats the timeout.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = mis ? EXC : REQ;
                end
            end
            REQ: begin
                if (mem.mem_gnt) begin
                    state_n = WAIT;
                end else if (timeout) begin
                    state_n = EXC;
                end
            end
            WAIT: begin
                if (mem.mem_rvalid) begin
                    state_n = DONE;
                end else if (timeout) begin
                    state_n = EXC;
                end
            end
            DONE:    state_n = IDLE;
            EXC:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_be    <= '0;
            mem.mem_wdata <= '0;
            wb_valid      <= 1'b0;
            wb_rd         <= '0;
            wb_data       <= '0;
            exc_valid     <= 1'b0;
            exc_cause     <= '0;
            exc_addr      <= '0;
            addr_q        <= '0;
            st_q          <= 1'b0;
            uns_q         <= 1'b0;
            sz_q          <= '0;
            rd_q          <= '0;
        end else begin
            mem.mem_req <= (state_n == REQ);
            exc_valid   <= (state_n == EXC);
            wb_valid    <= 1'b0;

            if (state == IDLE) begin
                cnt <= '0;
            end else if ((state == REQ) || (state == WAIT)) begin
                cnt <= cnt + 1'b1;
            end

            if ((state == IDLE) && accept) begin
                addr_q <= op_addr;
                st_q   <= is_st;
                uns_q  <= f3[2];
                sz_q   <= f3[1:0];
                rd_q   <= op_rd;
                if (mis) begin
                    exc_cause <= is_st ? 2'b10 : 2'b01;
                    exc_addr  <= op_addr;
                end else begin
                    mem.mem_we    <= is_st;
                    mem.mem_addr  <= {op_addr[31:2], 2'b00};
                    mem.mem_be    <= be_d;
                    mem.mem_wdata <= wdata_d;
                end
            end

            if (((state == REQ) || (state == WAIT))
                && (state_n == EXC)) begin
                exc_cause <= 2'b11;
                exc_addr  <= addr_q;
            end

            if ((state == WAIT) && mem.mem_rvalid && !st_q) begin
                wb_valid <= 1'b1;
                wb_rd    <= rd_q;
                wb_data  <= ld_data;
            end
        end
    end

endmodule

// File: doc/lsu_controller.md
# lsu_controller

Load/store sequencing controller between the RV32I execute stage and the data-memory port. It accepts one decoded load/store per transaction (LB/LH/LW/LBU/LHU/SB/SH/SW) and drives a request/grant/response handshake to memory. It stalls the pipeline for the duration of the access, then returns sign- or zero-extended load data to writeback. Misaligned accesses and bus timeouts are raised as exceptions.

## Interface
- TIMEOUT, 255: max cycles spent in REQ+WAIT before bus-timeout exception (≥2).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  EX stage presents an instruction this cycle.
- op_code  in  10  {funct3, opcode}; legal values are the load encodings (opcode 0000011, funct3 000/001/010/100/101) and store encodings (opcode 0100011, funct3 000/001/010).
- op_addr  in  32  effective address (rs1 + imm).
- op_wdata  in  32  store data (rs2).
- op_rd  in  5  load destination register.
- stall  out  1  holds IF/ID/EX while high.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = store.
- mem_addr  out  32  word-aligned address {op_addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  request accepted (sampled only while mem_req=1).
- mem_rvalid  in  1  response/ack (sampled only in WAIT).
- mem_rdata  in  32  load data, valid with mem_rvalid.
- wb_valid  out  1  one-cycle load result pulse.
- wb_rd  out  5  load destination.
- wb_data  out  32  extended load data.
- exc_valid  out  1  one-cycle exception pulse.
- exc_cause  out  2  01 misaligned load, 10 misaligned store, 11 bus timeout.
- exc_addr  out  32  faulting op_addr (unaligned, as presented).

## Operation
- States: IDLE, REQ, WAIT, DONE, EXC.
- IDLE: op_valid with legal op_code is accepted. Aligned → capture address/be/wdata/rd/type, go to REQ. Misaligned (half with addr[0]=1; word with addr[1:0]≠0) → go to EXC with cause 01/10. Illegal op_code or op_valid=0 → stay; no stall.
- REQ: mem_req=1 with stable mem_we/addr/be/wdata until mem_gnt=1, then WAIT.
- WAIT: on mem_rvalid → capture rdata, go to DONE. Stores also wait for mem_rvalid (write ack).
- DONE: one cycle. wb_valid=1 for loads (0 for stores). op_* inputs ignored. Next state IDLE.
- EXC: one cycle, exc_valid=1, op_* ignored, next state IDLE.
- stall = (IDLE & op_valid & legal op) | REQ | WAIT. Low in DONE and EXC, so EX advances exactly once per transaction.
- Byte enables: SB 0001<<addr[1:0]; SH addr[1]?1100:0011; SW 1111.
- Store data: SB {4{b[7:0]}}; SH {2{h[15:0]}}; SW as is.
- Load extraction: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passthrough.
- Timeout: counter clears on entering REQ and increments each cycle in REQ/WAIT. If it reaches TIMEOUT-1 with no gnt (REQ) or rvalid (WAIT) that cycle → EXC with cause 11, mem_req dropped. A completion event in the same cycle wins over timeout.

## Timing
- Reset: state IDLE; all outputs 0 (stall, mem_req, mem_we, mem_addr, mem_be, mem_wdata, wb_*, exc_*); counter 0.
- All outputs are registered except stall, which is combinational from state/op_valid/op_code.
- Best case (gnt in first REQ cycle, rvalid in first WAIT cycle): accept in cycle 0, mem_req in cycle 1, WAIT in cycle 2, wb_valid in cycle 3, IDLE in cycle 4.
- mem_rvalid in the same cycle as mem_gnt is ignored. Memory responds no earlier than the cycle after grant.
- Misaligned op: exc_valid in the cycle after acceptance; stall high only in the acceptance cycle.
- rst mid-transaction: next cycle IDLE with mem_req=0. A late mem_rvalid arriving in IDLE is ignored, with no wb_valid.
- Back-to-back: a new op can be accepted in the cycle after DONE/EXC.

## Test plan
- LW addr 0x1000, gnt immediately, rdata 0xDEADBEEF one cycle later → mem_be=1111, mem_addr=0x1000, wb_valid in cycle 3, wb_data=0xDEADBEEF, stall high cycles 0–2.
- LB addr 0x2003, rdata 0x80FF_0000 → mem_be=1000, wb_data=0xFFFFFF80. Same with LBU → 0x00000080. LH addr 0x2002 → 0xFFFF80FF.
- SH addr 0x3002, wdata 0x1234ABCD, gnt delayed 3 cycles → mem_req held 4 cycles with stable mem_be=1100 and mem_wdata=0xABCDABCD. After ack: wb_valid=0, stall drops.
- LW addr 0x1001 → no mem_req, exc_valid=1, exc_cause=01, exc_addr=0x1001. SW addr 0x1002 → cause 10.
- TIMEOUT=4, gnt never asserted → mem_req for 4 cycles, then exc_cause=11. Repeat with rvalid on the final cycle → wb_valid, no exception.
- rst asserted in WAIT, then mem_rvalid pulses → all outputs 0 and no wb_valid. A following LW completes normally.
